// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver
// ---------------------------------------------------------------------------
// Decoder for NEC-protocol infrared frames taken from a demodulated receiver
// output. The line is synchronised, mark/space durations are measured in
// 10 us ticks, and a state machine checks the leader, 32 data bits and the
// stop mark, or a repeat code. Results come out as registered one-cycle
// pulses.
//
// Parameters
//   CLOCK_SPEED : clk frequency in Hz (tick prescaler = CLOCK_SPEED/100000)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   ir_in in   demodulated IR line, asynchronous, low = mark
//   addr  out  [7:0] address byte of the last accepted frame
//   cmd   out  [7:0] command byte of the last accepted frame
//   valid out  one-cycle pulse when a full frame is accepted
//   rpt   out  one-cycle pulse when a repeat code is accepted
//   err   out  one-cycle pulse when a frame is aborted
//
// Build option
//   IR_RX_INVCHECK_EN : when defined, a frame is accepted only if
//                       byte1 == ~byte0 and byte3 == ~byte2; otherwise
//                       err is pulsed instead of valid.
// ---------------------------------------------------------------------------
module ir_nec_receiver #(
    parameter int CLOCK_SPEED = 8000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic [7:0] addr,
    output logic [7:0] cmd,
    output logic       valid,
    output logic       rpt,
    output logic       err
);

    localparam int DIV = CLOCK_SPEED / 100000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        RPT_MARK   = 3'd6
    } state_t;

    // Inclusive window test on a measured duration.
    function automatic logic in_range(input logic [10:0] v,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Frame integrity: each odd byte must be the complement of the byte below.
    function automatic logic inv_ok(input logic [31:0] frame);
        return (frame[15:8] == ~frame[7:0]) && (frame[31:24] == ~frame[23:16]);
    endfunction

    logic          sync1_r, sync2_r, prev_r;
    logic [PW-1:0] presc_r;
    logic [10:0]   dur_r;
    state_t        state_r, state_nx_s;
    logic [31:0]   shift_r, shift_nx_s;
    logic [4:0]    bit_idx_r, bit_idx_nx_s;
    logic          valid_nx_s, rpt_nx_s, err_nx_s, load_s;
    logic          fall_s, rise_s, edge_s, tick_s, timeout_s;

    assign fall_s    = prev_r & ~sync2_r;
    assign rise_s    = ~prev_r & sync2_r;
    assign edge_s    = fall_s | rise_s;
    assign tick_s    = (presc_r == PRESC_LAST);
    assign timeout_s = (dur_r >= 11'd1200);

    // Two-flop synchroniser plus edge-history flop; all preset to idle-high,
    // so a line held low through reset shows up as a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= ir_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // 10 us tick prescaler and saturating duration counter, both restarted on every edge.
    always_ff @(posedge clk) begin
        if (rst || edge_s) begin
            presc_r <= '0;
            dur_r   <= 11'd0;
        end else begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
            if (tick_s && (dur_r != 11'd2047)) begin
                dur_r <= dur_r + 11'd1;
            end
        end
    end

    // FSM state, shift register and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= 32'd0;
            bit_idx_r <= 5'd0;
        end else begin
            state_r   <= state_nx_s;
            shift_r   <= shift_nx_s;
            bit_idx_r <= bit_idx_nx_s;
        end
    end

    // Next-state decode: each edge closes one measured interval.
    always_comb begin
        state_nx_s   = state_r;
        shift_nx_s   = shift_r;
        bit_idx_nx_s = bit_idx_r;
        valid_nx_s   = 1'b0;
        rpt_nx_s     = 1'b0;
        err_nx_s     = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_nx_s = LEAD_MARK;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LEAD_MARK: begin
                if (rise_s) begin
                    if (in_range(dur_r, 11'd800, 11'd1000)) begin
                        state_nx_s = LEAD_SPACE;
                    end else begin
                        state_nx_s = IDLE;
                        err_nx_s   = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    state_nx_s = LEAD_MARK;
                end
            end
            LEAD_SPACE: begin
                if (fall_s) begin
                    if (in_range(dur_r, 11'd400, 11'd500)) begin
                        state_nx_s   = BIT_MARK;
                        bit_idx_nx_s = 5'd0;
                    end else if (in_range(dur_r, 11'd200, 11'd250)) begin
                        state_nx_s = RPT_MARK;
                    end else begin
                        state_nx_s = IDLE;
                        err_nx_s   = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    state_nx_s = LEAD_SPACE;
                end
            end
            BIT_MARK, STOP_MARK, RPT_MARK: begin
                if (rise_s) begin
                    if (!in_range(dur_r, 11'd40, 11'd70)) begin
                        state_nx_s = IDLE;
                        err_nx_s   = 1'b1;
                    end else if (state_r == BIT_MARK) begin
                        state_nx_s = BIT_SPACE;
                    end else if (state_r == RPT_MARK) begin
                        state_nx_s = IDLE;
                        rpt_nx_s   = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
`ifdef IR_RX_INVCHECK_EN
                        if (inv_ok(shift_r)) begin
                            valid_nx_s = 1'b1;
                            load_s     = 1'b1;
                        end else begin
                            err_nx_s   = 1'b1;
                        end
`else
                        valid_nx_s = 1'b1;
                        load_s     = 1'b1;
`endif
                    end
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            BIT_SPACE: begin
                if (fall_s) begin
                    if (in_range(dur_r, 11'd40, 11'd70) || in_range(dur_r, 11'd130, 11'd200)) begin
                        // LSB first: new bits enter at the top and move down.
                        shift_nx_s   = {in_range(dur_r, 11'd130, 11'd200), shift_r[31:1]};
                        bit_idx_nx_s = bit_idx_r + 5'd1;
                        state_nx_s   = (bit_idx_r == 5'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        state_nx_s = IDLE;
                        err_nx_s   = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                    err_nx_s   = 1'b1;
                end else begin
                    state_nx_s = BIT_SPACE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Registered result pulses and the held address/command bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            rpt   <= 1'b0;
            err   <= 1'b0;
            addr  <= 8'd0;
            cmd   <= 8'd0;
        end else begin
            valid <= valid_nx_s;
            rpt   <= rpt_nx_s;
            err   <= err_nx_s;
            if (load_s) begin
                addr <= shift_r[7:0];
                cmd  <= shift_r[23:16];
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_receiver.sv
`timescale 1ns/1ns
// Testbench for ir_nec_receiver. Runs the design at 200 kHz so one 10 us
// tick is two clocks. Expected events are queued as stimulus is driven and
// compared by a monitor whenever valid/rpt/err fires.
module tb_ir_nec_receiver;

    localparam int CLK_HZ = 200000;
    localparam logic [2:0] EV_VALID = 3'b100;
    localparam logic [2:0] EV_RPT   = 3'b010;
    localparam logic [2:0] EV_ERR   = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       ir_in;
    logic [7:0] addr, cmd;
    logic       valid, rpt, err;

    typedef struct packed {
        logic [2:0] flags;
        logic [7:0] a;
        logic [7:0] c;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] cur_cmd  = 8'h00;

    ir_nec_receiver #(.CLOCK_SPEED(CLK_HZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .ir_in (ir_in),
        .addr  (addr),
        .cmd   (cmd),
        .valid (valid),
        .rpt   (rpt),
        .err   (err)
    );

    always #2500 clk = ~clk;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid || rpt || err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got flags=%b addr=%h cmd=%h, required no event",
                         {valid, rpt, err}, addr, cmd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({valid, rpt, err} !== mon_e.flags || addr !== mon_e.a || cmd !== mon_e.c) begin
                    errors++;
                    $display("FAIL sb_event: got flags=%b addr=%h cmd=%h, required flags=%b addr=%h cmd=%h",
                             {valid, rpt, err}, addr, cmd, mon_e.flags, mon_e.a, mon_e.c);
                end
            end
        end
    end

    task automatic hold(input logic lvl, input int ticks);
        ir_in = lvl;
        repeat (ticks * 2) @(negedge clk);
    endtask

    task automatic send_leader(input int space_ticks);
        hold(1'b0, 900);
        hold(1'b1, space_ticks);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, 56);
            hold(1'b1, data[i] ? 169 : 56);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ir_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h, required 00", addr); end
        checks++;
        if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h, required 00", cmd); end
        checks++;
        if ({valid, rpt, err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b, required 000", {valid, rpt, err});
        end
        rst = 1'b0;
        hold(1'b1, 20);
    endtask

    task automatic test_frame(input logic [7:0] a, input logic [7:0] b1,
                              input logic [7:0] c, input logic [7:0] b3);
        logic ok;
        send_leader(450);
        send_bits({b3, c, b1, a}, 32);
`ifdef IR_RX_INVCHECK_EN
        ok = (b1 == ~a) && (b3 == ~c);
`else
        ok = 1'b1;
`endif
        if (ok) begin
            cur_addr = a;
            cur_cmd  = c;
            exp_q.push_back({EV_VALID, a, c});
        end else begin
            exp_q.push_back({EV_ERR, cur_addr, cur_cmd});
        end
        hold(1'b0, 56);
        ir_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ((valid | rpt | err) !== 1'b0) begin
            errors++; $display("FAIL frame_early: got pulse at cycle 2, required none");
        end
        @(negedge clk);
        checks++;
        if ((valid | rpt | err) !== 1'b1) begin
            errors++; $display("FAIL frame_latency: got no pulse at cycle 3, required pulse");
        end
        hold(1'b1, 100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL frame_pending: got %0d unconsumed events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_repeat();
        send_leader(225);
        exp_q.push_back({EV_RPT, cur_addr, cur_cmd});
        hold(1'b0, 56);
        ir_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rpt !== 1'b0) begin errors++; $display("FAIL repeat_early: got rpt=1 at cycle 2, required 0"); end
        @(negedge clk);
        checks++;
        if (rpt !== 1'b1) begin errors++; $display("FAIL repeat_latency: got rpt=%b at cycle 3, required 1", rpt); end
        hold(1'b1, 100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL repeat_pending: got %0d unconsumed events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_leader();
        exp_q.push_back({EV_ERR, cur_addr, cur_cmd});
        hold(1'b0, 500);
        ir_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL badlead_early: got err=1 at cycle 2, required 0"); end
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL badlead_latency: got err=%b at cycle 3, required 1", err); end
        hold(1'b1, 100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL badlead_pending: got %0d unconsumed events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_timeout();
        int first;
        send_leader(450);
        exp_q.push_back({EV_ERR, cur_addr, cur_cmd});
        ir_in = 1'b0;
        first = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (err === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first < 2395 || first > 2410) begin
            errors++; $display("FAIL timeout_cycle: got err at cycle %0d, required 2395..2410", first);
        end
        hold(1'b1, 100);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL timeout_pending: got %0d unconsumed events, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        send_leader(450);
        send_bits(32'h0000_0000, 16);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        cur_addr = 8'h00;
        cur_cmd  = 8'h00;
        checks++;
        if (addr !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h, required 00", addr); end
        checks++;
        if (cmd !== 8'h00) begin errors++; $display("FAIL midrst_cmd: got %h, required 00", cmd); end
        hold(1'b1, 100);
        checks++;
        if (exp_q.size() != 0 || addr !== 8'h00) begin
            errors++; $display("FAIL midrst_after: got pending=%0d addr=%h, required 0 and 00", exp_q.size(), addr);
            exp_q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        ir_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        test_repeat();
        test_bad_leader();
        test_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
        test_frame(8'h10, 8'hEE, 8'h22, 8'hDD);
        test_timeout();
        test_reset_mid_frame();
        test_frame(8'hA5, 8'h5A, 8'h0F, 8'hF0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_nec_receiver.md
IR_NEC_RECEIVER -- requirements
Module: ir_nec_receiver

Interface
REQ-001 SHALL have parameter CLOCK_SPEED, default 8000000, giving the clk frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ir_in  input  1  demodulated IR line, asynchronous, active-low (low = carrier present, "mark").
REQ-005 SHALL have port addr  output  8  address byte of the last accepted frame.
REQ-006 SHALL have port cmd  output  8  command byte of the last accepted frame.
REQ-007 SHALL have port valid  output  1  one-cycle pulse on accepting a full frame.
REQ-008 SHALL have port rpt  output  1  one-cycle pulse on accepting a repeat code.
REQ-009 SHALL have port err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-010 SHALL synchronise ir_in through 2 flops; edge detection SHALL use only the synchronised value.
REQ-011 SHALL derive a 10 us tick from a prescaler dividing by CLOCK_SPEED/100000 (80 at 8 MHz); the prescaler SHALL restart on every synchronised edge.
REQ-012 SHALL count ticks in an 11-bit duration counter that clears on every synchronised edge and saturates at 2047.
REQ-013 SHALL implement states IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK and RPT_MARK.
REQ-014 IDLE: a falling edge SHALL go to LEAD_MARK.
REQ-015 LEAD_MARK: on the rising edge, a count of 800-1000 SHALL go to LEAD_SPACE; any other count SHALL go to IDLE with err.
REQ-016 LEAD_SPACE: on the falling edge, a count of 400-500 SHALL go to BIT_MARK with bit index 0; 200-250 SHALL go to RPT_MARK; any other count SHALL go to IDLE with err.
REQ-017 BIT_MARK / STOP_MARK / RPT_MARK: on the rising edge, a count of 40-70 SHALL advance; any other count SHALL go to IDLE with err.
REQ-018 BIT_SPACE: on the falling edge, a count of 40-70 SHALL shift in bit 0 and 130-200 SHALL shift in bit 1; any other count SHALL go to IDLE with err.
REQ-019 Bits SHALL be received LSB first into a 32-bit shift register laid out as {~cmd, cmd, ~addr, addr}; after bit 31 the FSM SHALL go to STOP_MARK, otherwise back to BIT_MARK.
REQ-020 STOP_MARK accepted SHALL load addr/cmd, pulse valid and go to IDLE; RPT_MARK accepted SHALL pulse rpt with addr/cmd unchanged and go to IDLE.
REQ-021 In any non-IDLE state, a count reaching 1200 (12 ms) without an edge SHALL pulse err and go to IDLE.
REQ-022 Latency: valid/rpt/err SHALL assert on the 3rd rising clk edge after ir_in changes (2 sync + 1 register).
REQ-023 valid, rpt and err SHALL be mutually exclusive and SHALL each be high for exactly one cycle per event.
REQ-024 addr/cmd SHALL hold their values until the next valid; aborted frames SHALL never modify them.

Reset
REQ-025 rst SHALL set the FSM to IDLE, clear the prescaler, duration counter, shift register and bit index, and drive addr=0, cmd=0, valid=0, rpt=0, err=0.
REQ-026 rst SHALL preset both sync flops to 1 (idle line).
REQ-027 rst asserted mid-frame SHALL discard the partial frame with no valid/rpt/err pulse.
REQ-028 If ir_in is low when rst releases, the FSM SHALL treat it as a falling edge.

Configuration
REQ-029 With macro IR_RX_INVCHECK_EN defined, STOP_MARK acceptance SHALL additionally require byte1 == ~byte0 and byte3 == ~byte2; on mismatch it SHALL pulse err instead of valid.
REQ-030 Without IR_RX_INVCHECK_EN, the inverse bytes SHALL be ignored and only timing SHALL be checked.

Verification
REQ-031 NEC frame addr=0x00 cmd=0x45 (9 ms / 4.5 ms leader, 562 us marks, 562 us / 1687 us spaces, stop mark) -> one valid pulse, addr=0x00, cmd=0x45, no err.
REQ-032 Repeat code (9 ms mark, 2.25 ms space, 562 us mark) after REQ-031 -> one rpt pulse, addr=0x00, cmd=0x45 unchanged.
REQ-033 Frame addr=0x10 with byte1=0xEE (should be 0xEF) -> with IR_RX_INVCHECK_EN: err, addr stays at the prior value; without the macro: valid, addr=0x10.
REQ-034 5 ms leader mark -> err 3 cycles after the rising edge, FSM in IDLE; a following good frame decodes correctly.
REQ-035 Line held low 15 ms after a valid leader space -> err when the count reaches 1200, with no valid.
REQ-036 rst pulsed after 16 data bits -> no pulses; addr=0, cmd=0; the next full frame decodes correctly.
